fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO for pixel and line streams in the image pipeline. It generalises the basic synchronous FIFO with:
- arbitrary (non-power-of-two) depth
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost-full/almost-empty thresholds
- synchronous flush
- sticky error flags

It sits between producer/consumer stages that need early back-pressure.

Parameters:
- DATA_W, 10, data word width in bits (≥1)
- SIZE, 16, depth in words (≥2, any integer)
- FWFT, 0, 0 = standard read (data 1 cycle after rd_en); 1 = head word visible while !empty
- AFULL_LEVEL, SIZE-2, almost_full asserted when data_count ≥ AFULL_LEVEL (1..SIZE)
- AEMPTY_LEVEL, 2, almost_empty asserted when data_count ≤ AEMPTY_LEVEL (0..SIZE-1)

Ports:
- clk  in  1  clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of contents and pointers
- data_wr  in  DATA_W  write data
- wr_en  in  1  write request
- data_rd  out  DATA_W  read data
- rd_en  in  1  read request (pop)
- data_count  out  $clog2(SIZE)+1  words stored
- full  out  1  data_count == SIZE
- almost_full  out  1  data_count ≥ AFULL_LEVEL
- empty  out  1  data_count == 0
- almost_empty  out  1  data_count ≤ AEMPTY_LEVEL
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected
- err_sticky  out  2  {overflow_seen, underflow_seen}; cleared only by reset or flush

Behaviour:
- Reset (aresetn low, asynchronous, any time including mid-transfer):
  - pointers and count = 0, data_rd = 0
  - full = 0, almost_full = 0, empty = 1, almost_empty = 1
  - overflow = 0, underflow = 0, err_sticky = 0
- All outputs are registered; flags reflect the state after the last rising edge.
- Storage: wr_ptr/rd_ptr in 0..SIZE-1, wrapping from SIZE-1 to 0 (explicit compare, not modulo-2^n).
- Accept/reject rules, per edge:
  - A write is accepted iff wr_en && (!full || rd_accept).
  - A read is accepted iff rd_en && !empty.
  - When full and both rd_en and wr_en are high, both are accepted; count is unchanged and no overflow.
  - When empty and both are high, the write is accepted, the read is rejected, and underflow pulses.
  - A rejected write sets overflow = 1 for the next cycle only, sets err_sticky[1], and leaves memory/pointers untouched.
  - A rejected read sets underflow = 1 for the next cycle only, sets err_sticky[0], and leaves data_rd unchanged.
- Count: data_count_next = data_count + wr_accept - rd_accept. All flags are computed from data_count_next and registered, so they are valid the same cycle as data_count.
- FWFT = 0:
  - On an accepted read, data_rd <= mem[rd_ptr] at that edge, then rd_ptr advances.
  - Otherwise data_rd holds.
- FWFT = 1:
  - data_rd always presents mem[rd_ptr] when !empty and holds its last value when empty.
  - Write into an empty FIFO: the word appears on data_rd one cycle after the write edge, together with empty = 0.
  - An accepted read advances to the next word at the edge.
- Flush:
  - Highest priority after reset; overrides rd_en/wr_en in that cycle.
  - Pointers and count = 0, flags return to reset values, err_sticky = 0.
  - data_rd holds its value; memory contents are not cleared.
- No X propagation: memory is not reset, but data_rd never samples an unwritten location under legal use.

Decomposition:
- Shared package/header fifo_defs: count-width function (clog2(SIZE)+1) and FWFT mode constants (MODE_STD = 0, MODE_FWFT = 1), reused by the later async FIFO.
- Sub-module fifo_ram: simple dual-port memory, synchronous write, read-address-driven output, parameters DATA_W and SIZE.
- fifo_sync_flags holds pointers, count, flags and read-mode logic.

Test Plan:
1. Reset, then rd_en = 1 for 1 cycle with DATA_W = 8, SIZE = 6, FWFT = 0 -> next cycle underflow = 1, err_sticky = 2'b01, empty = 1, data_count = 0; following cycle underflow = 0, err_sticky holds.
2. Write 0x11..0x66 (6 words) with AFULL_LEVEL = 5 -> almost_full rises after the 5th write, full after the 6th; a 7th write with 0x77 gives overflow pulse, data_count = 6, err_sticky[1] = 1.
3. Full FIFO, rd_en = wr_en = 1 writing 0x77 -> no overflow, data_count stays 6, data_rd = 0x11 next cycle. Then read 6 more words -> 0x22, 0x33, 0x44, 0x55, 0x66, 0x77 in order, with wrap across index 5→0 verified.
4. FWFT = 1, empty FIFO, write 0xA5 -> one cycle later empty = 0 and data_rd = 0xA5 without rd_en. Then rd_en = 1 -> empty = 1, and data_rd holds 0xA5.
5. Load 4 words, assert flush together with wr_en = 1 -> data_count = 0, empty = 1, almost_empty = 1, err_sticky = 0, and the written word is discarded.
6. Drop aresetn mid-burst (3 words stored, wr_en high) -> all outputs at reset values immediately, without waiting for a clock edge. Release reset and write/read 0x3C -> data_rd = 0x3C, data_count back to 0.

Source files
------------

// File: rtl/fifo_defs_pkg.sv
// Shared FIFO definitions: count-width helper and read-mode constants,
// common to the synchronous and asynchronous FIFO families.
package fifo_defs;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // A count must represent 0..SIZE inclusive, hence one bit above the address width.
  function automatic int count_w(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, combinational read addressed by raddr.
module fifo_ram #(
  parameter int DATA_W = 10,
  parameter int SIZE   = 16,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [SIZE];

  // NOTE: the array has no reset so it maps onto RAM; readers only address written words.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with arbitrary depth, STD/FWFT read modes, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_sync_flags
  import fifo_defs::*;
#(
  parameter int DATA_W       = 10,
  parameter int SIZE         = 16,
  parameter int FWFT         = MODE_STD,
  parameter int AFULL_LEVEL  = SIZE - 2,
  parameter int AEMPTY_LEVEL = 2,
  localparam int AW          = $clog2(SIZE),
  localparam int CW          = count_w(SIZE)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              wr_en,
  output logic [DATA_W-1:0] data_rd,
  input  logic              rd_en,
  output logic [CW-1:0]     data_count,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [1:0]        err_sticky
);

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW-1:0]     wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]     count_nxt;
  logic [DATA_W-1:0] data_rd_nxt;
  logic [DATA_W-1:0] ram_rdata;
  logic [AW-1:0]     ram_raddr;
  logic              rd_accept, wr_accept;
  logic              wr_do, rd_do;
  logic              overflow_nxt, underflow_nxt;
  logic [1:0]        err_sticky_nxt;

  // Pointers wrap at SIZE-1 explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);
  assign wr_do     = wr_accept && !flush;
  assign rd_do     = rd_accept && !flush;

  // FWFT pre-fetches the head that will be current after this edge.
  assign ram_raddr = (FWFT == MODE_FWFT) ? rd_ptr_nxt : rd_ptr;

  fifo_ram #(
    .DATA_W (DATA_W),
    .SIZE   (SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_do),
    .waddr (wr_ptr),
    .wdata (data_wr),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    count_nxt      = data_count;
    data_rd_nxt    = data_rd;
    overflow_nxt   = 1'b0;
    underflow_nxt  = 1'b0;
    err_sticky_nxt = err_sticky;

    if (flush) begin
      wr_ptr_nxt     = '0;
      rd_ptr_nxt     = '0;
      count_nxt      = '0;
      err_sticky_nxt = 2'b00;
    end else begin
      if (wr_do) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (rd_do) rd_ptr_nxt = ptr_inc(rd_ptr);
      count_nxt      = data_count + CW'(wr_do) - CW'(rd_do);
      overflow_nxt   = wr_en && !wr_accept;
      underflow_nxt  = rd_en && !rd_accept;
      err_sticky_nxt = err_sticky | {overflow_nxt, underflow_nxt};

      if (FWFT == MODE_FWFT) begin
        // The sole remaining word is the one being written now: bypass the RAM.
        if (wr_do && count_nxt == CW'(1)) data_rd_nxt = data_wr;
        else if (count_nxt != '0)         data_rd_nxt = ram_rdata;
      end else if (rd_do) begin
        data_rd_nxt = ram_rdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      data_rd      <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      err_sticky   <= 2'b00;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      data_count   <= count_nxt;
      data_rd      <= data_rd_nxt;
      full         <= (count_nxt == CW'(SIZE));
      almost_full  <= (count_nxt >= CW'(AFULL_LEVEL));
      empty        <= (count_nxt == '0);
      almost_empty <= (count_nxt <= CW'(AEMPTY_LEVEL));
      overflow     <= overflow_nxt;
      underflow    <= underflow_nxt;
      err_sticky   <= err_sticky_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench: a standard-read instance and an FWFT instance, both 8-bit x 6 deep.
module tb_fifo_sync_flags;

  logic clk = 1'b0;
  logic aresetn = 1'b0;

  logic       s_flush = 0, s_wr_en = 0, s_rd_en = 0;
  logic [7:0] s_data_wr = '0, s_data_rd;
  logic [3:0] s_count;
  logic       s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
  logic [1:0] s_err;

  logic       f_flush = 0, f_wr_en = 0, f_rd_en = 0;
  logic [7:0] f_data_wr = '0, f_data_rd;
  logic [3:0] f_count;
  logic       f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
  logic [1:0] f_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.DATA_W(8), .SIZE(6), .FWFT(0), .AFULL_LEVEL(5), .AEMPTY_LEVEL(2)) dut_std (
    .clk(clk), .aresetn(aresetn), .flush(s_flush), .data_wr(s_data_wr), .wr_en(s_wr_en),
    .data_rd(s_data_rd), .rd_en(s_rd_en), .data_count(s_count), .full(s_full),
    .almost_full(s_afull), .empty(s_empty), .almost_empty(s_aempty),
    .overflow(s_ovf), .underflow(s_unf), .err_sticky(s_err));

  fifo_sync_flags #(.DATA_W(8), .SIZE(6), .FWFT(1), .AFULL_LEVEL(5), .AEMPTY_LEVEL(2)) dut_fwft (
    .clk(clk), .aresetn(aresetn), .flush(f_flush), .data_wr(f_data_wr), .wr_en(f_wr_en),
    .data_rd(f_data_rd), .rd_en(f_rd_en), .data_count(f_count), .full(f_full),
    .almost_full(f_afull), .empty(f_empty), .almost_empty(f_aempty),
    .overflow(f_ovf), .underflow(f_unf), .err_sticky(f_err));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_std_reset(input string tag);
    check({tag, " count"},  s_count,   0);
    check({tag, " empty"},  s_empty,   1);
    check({tag, " aempty"}, s_aempty,  1);
    check({tag, " full"},   s_full,    0);
    check({tag, " afull"},  s_afull,   0);
    check({tag, " ovf"},    s_ovf,     0);
    check({tag, " unf"},    s_unf,     0);
    check({tag, " err"},    s_err,     0);
    check({tag, " data"},   s_data_rd, 0);
  endtask

  initial begin
    logic [7:0] exp_rd [6];
    exp_rd[0] = 8'h22; exp_rd[1] = 8'h33; exp_rd[2] = 8'h44;
    exp_rd[3] = 8'h55; exp_rd[4] = 8'h66; exp_rd[5] = 8'h77;

    // Reset state
    #12;
    check_std_reset("rst");
    check("rst fwft empty", f_empty, 1);
    check("rst fwft data",  f_data_rd, 0);
    @(negedge clk);
    aresetn = 1'b1;
    tick();

    // 1: underflow on empty
    s_rd_en = 1; tick(); s_rd_en = 0;
    check("t1 unf",   s_unf,   1);
    check("t1 err",   s_err,   2'b01);
    check("t1 empty", s_empty, 1);
    check("t1 count", s_count, 0);
    tick();
    check("t1 unf drop", s_unf, 0);
    check("t1 err hold", s_err, 2'b01);

    // 2: fill to full, flag thresholds, overflow
    for (int i = 1; i <= 6; i++) begin
      s_wr_en = 1; s_data_wr = 8'(i * 8'h11); tick();
      check($sformatf("t2 count%0d", i), s_count, i);
      check($sformatf("t2 afull%0d", i), s_afull, (i >= 5) ? 1 : 0);
      check($sformatf("t2 full%0d", i),  s_full,  (i == 6) ? 1 : 0);
      check($sformatf("t2 aempty%0d", i), s_aempty, (i <= 2) ? 1 : 0);
    end
    s_data_wr = 8'h77; tick(); s_wr_en = 0;
    check("t2 ovf",   s_ovf,   1);
    check("t2 count", s_count, 6);
    check("t2 err",   s_err,   2'b11);
    tick();
    check("t2 ovf drop", s_ovf, 0);

    // 3: simultaneous read/write while full, then drain across the wrap
    s_wr_en = 1; s_rd_en = 1; s_data_wr = 8'h77; tick(); s_wr_en = 0;
    check("t3 ovf",   s_ovf,     0);
    check("t3 count", s_count,   6);
    check("t3 full",  s_full,    1);
    check("t3 data",  s_data_rd, 8'h11);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t3 rd%0d", i), s_data_rd, exp_rd[i]);
      check($sformatf("t3 cnt%0d", i), s_count, 5 - i);
    end
    s_rd_en = 0;
    check("t3 empty", s_empty, 1);
    s_rd_en = 1; tick(); s_rd_en = 0;
    check("t3 unf",       s_unf,     1);
    check("t3 data hold", s_data_rd, 8'h77);

    // 4: FWFT head visibility
    f_wr_en = 1; f_data_wr = 8'hA5; tick(); f_wr_en = 0;
    check("t4 empty", f_empty,   0);
    check("t4 data",  f_data_rd, 8'hA5);
    check("t4 count", f_count,   1);
    f_rd_en = 1; tick(); f_rd_en = 0;
    check("t4 empty2", f_empty,   1);
    check("t4 hold",   f_data_rd, 8'hA5);
    f_wr_en = 1; f_data_wr = 8'hB1; tick();
    check("t4 b1", f_data_rd, 8'hB1);
    f_data_wr = 8'hB2; tick(); f_wr_en = 0;
    check("t4 b1 stays", f_data_rd, 8'hB1);
    f_rd_en = 1; tick(); f_rd_en = 0;
    check("t4 b2", f_data_rd, 8'hB2);
    f_rd_en = 1; f_wr_en = 1; f_data_wr = 8'hC3; tick(); f_rd_en = 0; f_wr_en = 0;
    check("t4 c3 bypass", f_data_rd, 8'hC3);
    check("t4 c3 count",  f_count,   1);

    // 5: flush discards contents and the coincident write
    for (int i = 0; i < 4; i++) begin
      s_wr_en = 1; s_data_wr = 8'(8'hA1 + i); tick();
    end
    check("t5 count pre", s_count, 4);
    s_flush = 1; s_data_wr = 8'hEE; tick(); s_flush = 0; s_wr_en = 0;
    check("t5 count",  s_count,   0);
    check("t5 empty",  s_empty,   1);
    check("t5 aempty", s_aempty,  1);
    check("t5 err",    s_err,     0);
    check("t5 data",   s_data_rd, 8'h77);
    s_rd_en = 1; tick(); s_rd_en = 0;
    check("t5 discarded", s_unf, 1);
    s_wr_en = 1; s_data_wr = 8'h5A; tick(); s_wr_en = 0;
    s_rd_en = 1; tick(); s_rd_en = 0;
    check("t5 new word", s_data_rd, 8'h5A);

    // 6: asynchronous reset mid-burst
    s_wr_en = 1;
    for (int i = 1; i <= 3; i++) begin
      s_data_wr = 8'(i); tick();
    end
    check("t6 count pre", s_count, 3);
    #2 aresetn = 1'b0;
    #1;
    check_std_reset("t6 async");
    s_wr_en = 0;
    @(negedge clk);
    aresetn = 1'b1;
    s_wr_en = 1; s_data_wr = 8'h3C; tick(); s_wr_en = 0;
    check("t6 count1", s_count, 1);
    s_rd_en = 1; tick(); s_rd_en = 0;
    check("t6 data",  s_data_rd, 8'h3C);
    check("t6 count", s_count,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
